// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and limits for the clock divider controller
package div_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2} state_e;
  localparam int MIN_DIV = 2;
endpackage

// File: rtl/clk_div_phase_gen.sv
// clk_div_phase_gen: phase counter and 50%-duty output for divisor n_i
module clk_div_phase_gen #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] n_i,
  output logic             outp_o,
  output logic             wrap_o
);
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic p_q, p_d, pn_q;
  assign wrap_o = run_i && cnt_q == n_i - WIDTH'(1);
  // n_i only changes while cnt_d is 0, so the current n_i is valid for p_d
  always_comb begin
    cnt_d = (clear_i || wrap_o) ? '0 : run_i ? cnt_q + WIDTH'(1) : cnt_q;
    p_d   = cnt_d >= (n_i >> 1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      p_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      p_q   <= p_d;
    end
  end
  always_ff @(negedge clk or posedge rst) begin
    if (rst) pn_q <= 1'b0;
    else     pn_q <= p_q;
  end
  assign outp_o = n_i[0] ? (p_q & pn_q) : p_q;
endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run/stop sequencing and glitch-free divisor updates for the phase generator
module clk_div_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic [WIDTH-1:0] div_cur,
  output logic             running,
  output logic             period_tick,
  output logic             outp
);
  state_e st_q, st_d;
  logic [WIDTH-1:0] div_q, div_d, pend_div_q, pend_div_d;
  logic pend_q, pend_d, err_q, err_d;
  logic wrap, active, acc, bad;
  assign active = st_q != ST_IDLE;
  // a pending divisor lands at the period boundary, or at once if we fell idle
  always_comb begin
    acc        = cfg_valid && !pend_q;
    bad        = cfg_div < WIDTH'(MIN_DIV);
    err_d      = acc && bad;
    st_d       = en ? ST_RUN : (active && !wrap) ? ST_DRAIN : ST_IDLE;
    pend_d     = pend_q;
    pend_div_d = pend_div_q;
    div_d      = div_q;
    if (pend_q && (wrap || !active)) begin
      div_d  = pend_div_q;
      pend_d = 1'b0;
    end
    if (acc && !bad) begin
      if (active) begin
        pend_d     = 1'b1;
        pend_div_d = cfg_div;
      end else div_d = cfg_div;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q       <= ST_IDLE;
      div_q      <= WIDTH'(DEFAULT_DIV);
      pend_div_q <= '0;
      pend_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      st_q       <= st_d;
      div_q      <= div_d;
      pend_div_q <= pend_div_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
    end
  end
  assign cfg_ready   = !pend_q;
  assign cfg_err     = err_q;
  assign div_cur     = div_q;
  assign running     = active;
  assign period_tick = wrap;
  clk_div_phase_gen #(.WIDTH(WIDTH)) u_phase (
    .clk     (clk),
    .rst     (rst),
    .run_i   (active),
    .clear_i (!active),
    .n_i     (div_q),
    .outp_o  (outp),
    .wrap_o  (wrap)
  );
endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: vector table, corner sequences and randomized run against a period model
module tb_clk_div_ctrl;
  logic clk = 1'b0;
  logic rst, en, cfg_valid;
  logic [7:0] cfg_div;
  logic cfg_ready, cfg_err, running, period_tick, outp;
  logic [7:0] div_cur;
  int total = 0;
  int bad = 0;
  bit m_active, m_pv, m_err;
  int m_pos, m_n, m_pd;
  bit s_ready, s_err, s_run, s_tick, s_outp;
  logic [7:0] s_div;

  typedef struct {
    bit e; bit v; logic [7:0] d;
    bit rdy; bit err; logic [7:0] dv; bit run; bit tick; bit o;
  } vec_t;
  vec_t tbl[13];

  clk_div_ctrl #(.WIDTH(8), .DEFAULT_DIV(3)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .div_cur(div_cur), .running(running),
    .period_tick(period_tick), .outp(outp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_pv = 0; m_err = 0; m_pos = 0; m_n = 3; m_pd = 0;
  endtask

  // Period model: output is high for the last N half-cycles of each 2N-half-cycle period
  task automatic model_edge(input bit e, input bit v, input int d);
    bit wrap;
    bit acc;
    int nn;
    wrap = m_active && m_pos == m_n - 1;
    acc = v && !m_pv;
    nn = m_n;
    m_err = acc && d < 2;
    if (m_pv && (wrap || !m_active)) begin
      nn = m_pd;
      m_pv = 0;
    end
    if (acc && d >= 2) begin
      if (m_active) begin
        m_pv = 1;
        m_pd = d;
      end else nn = d;
    end
    m_pos = (m_active && !wrap) ? m_pos + 1 : 0;
    m_active = (m_active && !wrap) ? 1'b1 : e;
    m_n = nn;
  endtask

  task automatic step(input bit e, input bit v, input logic [7:0] d);
    en = e; cfg_valid = v; cfg_div = d;
    @(posedge clk);
    model_edge(e, v, int'(d));
    #1;
    s_ready = cfg_ready; s_err = cfg_err; s_div = div_cur;
    s_run = running; s_tick = period_tick; s_outp = outp;
    chk("ready", int'(cfg_ready), int'(!m_pv));
    chk("err", int'(cfg_err), int'(m_err));
    chk("div_cur", int'(div_cur), m_n);
    chk("running", int'(running), int'(m_active));
    chk("tick", int'(period_tick), int'(m_active && m_pos == m_n - 1));
    chk("outp_first_half", int'(outp), int'(m_active && 2 * m_pos >= m_n));
    @(negedge clk);
    #1;
    chk("outp_second_half", int'(outp), int'(m_active && 2 * m_pos + 1 >= m_n));
  endtask

  initial begin
    bit re, rv;
    logic [7:0] rd;
    tbl[0]  = '{1, 0, 8'd0, 1, 0, 8'd3, 1, 0, 0};
    tbl[1]  = '{1, 0, 8'd0, 1, 0, 8'd3, 1, 0, 0};
    tbl[2]  = '{1, 0, 8'd0, 1, 0, 8'd3, 1, 1, 1};
    tbl[3]  = '{1, 1, 8'd5, 0, 0, 8'd3, 1, 0, 0};
    tbl[4]  = '{1, 0, 8'd0, 0, 0, 8'd3, 1, 0, 0};
    tbl[5]  = '{1, 0, 8'd0, 0, 0, 8'd3, 1, 1, 1};
    tbl[6]  = '{1, 0, 8'd0, 1, 0, 8'd5, 1, 0, 0};
    tbl[7]  = '{1, 1, 8'd1, 1, 1, 8'd5, 1, 0, 0};
    tbl[8]  = '{1, 1, 8'd0, 1, 1, 8'd5, 1, 0, 0};
    tbl[9]  = '{1, 0, 8'd0, 1, 0, 8'd5, 1, 0, 1};
    tbl[10] = '{0, 0, 8'd0, 1, 0, 8'd5, 1, 1, 1};
    tbl[11] = '{0, 0, 8'd0, 1, 0, 8'd5, 0, 0, 0};
    tbl[12] = '{0, 0, 8'd0, 1, 0, 8'd5, 0, 0, 0};

    rst = 1; en = 0; cfg_valid = 0; cfg_div = 0;
    #3;
    chk("rst_ready", int'(cfg_ready), 1);
    chk("rst_err", int'(cfg_err), 0);
    chk("rst_div", int'(div_cur), 3);
    chk("rst_running", int'(running), 0);
    chk("rst_tick", int'(period_tick), 0);
    chk("rst_outp", int'(outp), 0);
    rst = 0;
    model_reset();

    foreach (tbl[i]) begin
      step(tbl[i].e, tbl[i].v, tbl[i].d);
      chk($sformatf("vec%0d_ready", i), int'(s_ready), int'(tbl[i].rdy));
      chk($sformatf("vec%0d_err", i), int'(s_err), int'(tbl[i].err));
      chk($sformatf("vec%0d_div", i), int'(s_div), int'(tbl[i].dv));
      chk($sformatf("vec%0d_running", i), int'(s_run), int'(tbl[i].run));
      chk($sformatf("vec%0d_tick", i), int'(s_tick), int'(tbl[i].tick));
      chk($sformatf("vec%0d_outp", i), int'(s_outp), int'(tbl[i].o));
    end

    // N=4 from idle: first rising edge of outp two cycles into RUN
    step(0, 1, 8'd4);
    chk("idle_load_div4", int'(div_cur), 4);
    step(1, 0, 8'd0);
    chk("n4_c0_low", int'(s_outp), 0);
    step(1, 0, 8'd0);
    chk("n4_c1_low", int'(s_outp), 0);
    step(1, 0, 8'd0);
    chk("n4_c2_high", int'(s_outp), 1);
    for (int i = 0; i < 5; i++) step(1, 0, 8'd0);

    // N=5: drop en mid-period then re-raise before the wrap
    step(1, 1, 8'd5);
    while (!(m_active && m_pos == m_n - 1)) step(1, 0, 8'd0);
    step(1, 0, 8'd0);
    chk("n5_applied", int'(div_cur), 5);
    step(0, 0, 8'd0);
    step(0, 0, 8'd0);
    step(1, 0, 8'd0);
    step(1, 0, 8'd0);
    step(1, 0, 8'd0);
    chk("reraise_no_gap", int'(running), 1);
    for (int i = 0; i < 4; i++) step(1, 0, 8'd0);

    // Reset while outp high with a divisor pending
    step(0, 0, 8'd0);
    while (m_active) step(0, 0, 8'd0);
    step(0, 1, 8'd3);
    step(1, 0, 8'd0);
    step(1, 1, 8'd7);
    step(1, 0, 8'd0);
    chk("pre_rst_outp", int'(outp), 1);
    chk("pre_rst_pending", int'(cfg_ready), 0);
    rst = 1;
    #1;
    chk("async_rst_outp", int'(outp), 0);
    chk("async_rst_running", int'(running), 0);
    chk("async_rst_ready", int'(cfg_ready), 1);
    rst = 0;
    model_reset();
    chk("post_rst_div", int'(div_cur), 3);
    for (int i = 0; i < 7; i++) step(1, 0, 8'd0);
    chk("pending_lost", int'(div_cur), 3);

    re = 1; rv = 0; rd = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) re = !re;
      if (!(rv && m_pv)) begin
        rv = $urandom_range(0, 4) == 0;
        rd = 8'($urandom_range(0, 9));
      end
      step(re, rv, rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
